// File: rtl/result_bram_reader.sv
// Drains the 8192-entry circular FP16 result buffer (512 x 256-bit BRAM) onto a 16-bit valid/ready stream.
// Optional RESULT_BRAM_READER_STATS_EN adds o_beat_count / o_stall_count.
module result_bram_reader #(
    parameter int RD_LATENCY = 1,
    parameter int WR_PTR_DLY = 1
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_enable,
    input  logic         i_flush,
    input  logic [12:0]  i_wr_ptr,
    output logic [8:0]   o_bram_rd_addr,
    output logic         o_bram_rd_en,
    input  logic [255:0] i_bram_rd_data,
    output logic [15:0]  o_m_data,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic [12:0]  o_rd_ptr,
    output logic [13:0]  o_used_entries,
    output logic         o_empty,
    output logic         o_busy
`ifdef RESULT_BRAM_READER_STATS_EN
    ,
    output logic [31:0]  o_beat_count,
    output logic [31:0]  o_stall_count
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, STREAM} state_t;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    state_t       state;
    logic [12:0]  wr_pipe [WR_PTR_DLY];
    logic [12:0]  wr_ptr_d;
    logic [12:0]  diff;
    logic [13:0]  used;
    logic [3:0]   idx;
    logic [3:0]   idx_nx;
    logic [14:0]  lim_sum;
    logic [4:0]   lim_nx;
    logic [4:0]   lim;
    logic         last;
    logic         hs;
    logic [1:0]   wait_cnt;
    logic [255:0] line_buf;

    // The writer bumps its pointer before the BRAM write lands, so only the delayed copy is trusted.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < WR_PTR_DLY; i++) wr_pipe[i] <= '0;
        end else begin
            wr_pipe[0] <= i_wr_ptr;
            for (int i = 1; i < WR_PTR_DLY; i++) wr_pipe[i] <= wr_pipe[i-1];
        end
    end

    assign wr_ptr_d = wr_pipe[WR_PTR_DLY-1];
    assign diff     = wr_ptr_d - o_rd_ptr;
    assign used     = {1'b0, diff};
    assign idx      = o_rd_ptr[3:0];
    assign idx_nx   = idx + 4'd1;
    assign lim_sum  = {11'd0, idx} + {1'b0, used};
    assign lim_nx   = (lim_sum >= 15'd16) ? 5'd16 : lim_sum[4:0];
    assign last     = ({1'b0, idx} + 5'd1) == lim;
    assign hs       = o_m_valid & i_m_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            lim            <= '0;
            wait_cnt       <= '0;
            line_buf       <= '0;
            o_bram_rd_en   <= 1'b0;
            o_bram_rd_addr <= '0;
            o_m_valid      <= 1'b0;
            o_m_data       <= '0;
            o_rd_ptr       <= '0;
        end else if (i_flush) begin
            // Any read still in flight lands while IDLE and is simply never latched.
            state        <= IDLE;
            o_rd_ptr     <= wr_ptr_d;
            o_m_valid    <= 1'b0;
            o_bram_rd_en <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            o_bram_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_enable && used != 14'd0) begin
                        // Entries at or beyond lim are not yet written; a later fetch picks them up.
                        lim            <= lim_nx;
                        o_bram_rd_en   <= 1'b1;
                        o_bram_rd_addr <= o_rd_ptr[12:4];
                        state          <= FETCH;
                    end
                end
                FETCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        line_buf  <= i_bram_rd_data;
                        o_m_data  <= i_bram_rd_data[{idx, 4'b0} +: 16];
                        o_m_valid <= 1'b1;
                        state     <= STREAM;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        o_rd_ptr <= o_rd_ptr + 13'd1;
                        if (last) begin
                            o_m_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            o_m_data <= line_buf[{idx_nx, 4'b0} +: 16];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_used_entries = used;
    assign o_empty        = (used == 14'd0);
    assign o_busy         = (state != IDLE);

`ifdef RESULT_BRAM_READER_STATS_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_beat_count  <= '0;
            o_stall_count <= '0;
        end else if (i_flush) begin
            o_beat_count  <= '0;
            o_stall_count <= '0;
        end else begin
            if (hs) o_beat_count <= o_beat_count + 32'd1;
            if (o_m_valid && !i_m_ready) o_stall_count <= o_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_result_bram_reader.sv
// Bench for result_bram_reader: directed scenarios plus random traffic, checked against a
// pointer/array model of the circular buffer and a latency-exact BRAM responder.
module tb_result_bram_reader;

    localparam int LAT  = 1;
    localparam int WDLY = 1;

    logic         clk = 1'b0;
    logic         i_reset_n = 1'b1;
    logic         i_enable = 1'b0;
    logic         i_flush = 1'b0;
    logic [12:0]  i_wr_ptr = '0;
    logic [8:0]   o_bram_rd_addr;
    logic         o_bram_rd_en;
    logic [255:0] i_bram_rd_data = '0;
    logic [15:0]  o_m_data;
    logic         o_m_valid;
    logic         i_m_ready = 1'b0;
    logic [12:0]  o_rd_ptr;
    logic [13:0]  o_used_entries;
    logic         o_empty;
    logic         o_busy;

    always #5 clk = ~clk;

    result_bram_reader #(.RD_LATENCY(LAT), .WR_PTR_DLY(WDLY)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_flush(i_flush),
        .i_wr_ptr(i_wr_ptr), .o_bram_rd_addr(o_bram_rd_addr), .o_bram_rd_en(o_bram_rd_en),
        .i_bram_rd_data(i_bram_rd_data), .o_m_data(o_m_data), .o_m_valid(o_m_valid),
        .i_m_ready(i_m_ready), .o_rd_ptr(o_rd_ptr), .o_used_entries(o_used_entries),
        .o_empty(o_empty), .o_busy(o_busy)
    );

    logic [15:0] mem [8192];
    logic [12:0] m_rd;
    logic [12:0] m_wp [WDLY];
    logic        pv [4];
    logic [8:0]  pa [4];
    logic        stall_prev;
    logic [15:0] prev_data;
    logic [13:0] peak;
    logic [8:0]  last_addr;
    int          n_vec = 0, n_err = 0, n_beats = 0, n_fetch = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [8:0] a);
        logic [255:0] l;
        for (int k = 0; k < 16; k++) l[16*k +: 16] = mem[{a, 4'(k)}];
        return l;
    endfunction

    function automatic logic [255:0] garbage();
        logic [255:0] g;
        for (int k = 0; k < 8; k++) g[32*k +: 32] = $urandom;
        return g;
    endfunction

    // Called at a negedge with inputs set for the coming posedge; returns at the next negedge.
    task automatic step();
        logic        hs;
        logic [12:0] diff;
        diff = m_wp[WDLY-1] - m_rd;
        chk("rd_ptr", o_rd_ptr, m_rd);
        chk("used", o_used_entries, {1'b0, diff});
        chk("empty", o_empty, diff == 13'd0);
        if (o_used_entries > peak) peak = o_used_entries;
        if (stall_prev) begin
            chk("hold_valid", o_m_valid, 1'b1);
            chk("hold_data", o_m_data, prev_data);
        end
        if (o_bram_rd_en) begin
            n_fetch++;
            last_addr = o_bram_rd_addr;
            chk("rd_addr", o_bram_rd_addr, m_rd[12:4]);
        end
        hs = o_m_valid && i_m_ready && !i_flush;
        if (hs) begin
            chk("avail", m_rd != m_wp[WDLY-1], 1'b1);
            chk("data", o_m_data, mem[m_rd]);
            m_rd = m_rd + 13'd1;
            n_beats++;
        end
        if (i_flush) m_rd = m_wp[WDLY-1];
        stall_prev = o_m_valid && !i_m_ready && !i_flush;
        prev_data  = o_m_data;
        for (int j = 3; j > 0; j--) begin
            pv[j] = pv[j-1];
            pa[j] = pa[j-1];
        end
        pv[0] = o_bram_rd_en;
        pa[0] = o_bram_rd_addr;
        i_bram_rd_data = pv[LAT] ? line_of(pa[LAT]) : garbage();
        for (int j = WDLY - 1; j > 0; j--) m_wp[j] = m_wp[j-1];
        m_wp[0] = i_wr_ptr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_wr_ptr  = '0;
        i_flush   = 1'b0;
        i_enable  = 1'b0;
        i_m_ready = 1'b1;
        m_rd      = '0;
        for (int j = 0; j < WDLY; j++) m_wp[j] = '0;
        for (int j = 0; j < 4; j++) begin
            pv[j] = 1'b0;
            pa[j] = '0;
        end
        stall_prev = 1'b0;
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        bit done;
        done      = 1'b0;
        i_enable  = 1'b1;
        i_m_ready = 1'b1;
        for (int i = 0; i < 10000 && !done; i++) begin
            if (m_rd == i_wr_ptr && m_wp[WDLY-1] == i_wr_ptr && !o_busy && !o_m_valid) done = 1'b1;
            else step();
        end
        chk(tag, done, 1'b1);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int          f0, b0;
        logic [15:0] d0;
        logic [12:0] nw;

        for (int e = 0; e < 8192; e++) mem[e] = (e < 16) ? 16'(16'h1000 + e) : 16'($urandom);
        peak = '0;
        #1;
        do_reset();
        chk("rst_valid", o_m_valid, 1'b0);
        chk("rst_rd_en", o_bram_rd_en, 1'b0);
        chk("rst_rd_ptr", o_rd_ptr, 13'd0);
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_used", o_used_entries, 14'd0);
        chk("rst_busy", o_busy, 1'b0);

        // 1: five entries from line 0
        f0 = n_fetch; b0 = n_beats;
        i_wr_ptr = 13'd5;
        drain("t1_drain");
        chk("t1_beats", n_beats - b0, 5);
        chk("t1_fetch", n_fetch - f0, 1);
        chk("t1_addr", last_addr, 9'd0);
        chk("t1_rd_ptr", o_rd_ptr, 13'd5);
        chk("t1_empty", o_empty, 1'b1);

        // 2: partial line, then re-fetch of line 0 and line 1
        do_reset();
        f0 = n_fetch; b0 = n_beats;
        i_wr_ptr = 13'd3;
        drain("t2_drain_a");
        i_wr_ptr = 13'd20;
        drain("t2_drain_b");
        chk("t2_beats", n_beats - b0, 20);
        chk("t2_fetch", n_fetch - f0, 3);
        chk("t2_rd_ptr", o_rd_ptr, 13'd20);

        // 3: flush to 8190, then wrap line 511 -> line 0
        i_enable = 1'b0;
        i_wr_ptr = 13'd8190;
        repeat (WDLY + 1) step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("t3_flush_rd", o_rd_ptr, 13'd8190);
        peak = '0; b0 = n_beats;
        i_wr_ptr = 13'd2;
        drain("t3_drain");
        chk("t3_beats", n_beats - b0, 4);
        chk("t3_rd_ptr", o_rd_ptr, 13'd2);
        chk("t3_peak", peak, 14'd4);

        // 4: mid-line backpressure
        b0 = n_beats;
        i_wr_ptr = 13'd14;
        i_enable = 1'b1; i_m_ready = 1'b1;
        for (int i = 0; i < 100 && !(o_m_valid && m_rd == 13'd5); i++) step();
        chk("t4_reach", o_m_valid && m_rd == 13'd5, 1'b1);
        i_m_ready = 1'b0;
        d0 = o_m_data;
        repeat (10) step();
        chk("t4_hold_valid", o_m_valid, 1'b1);
        chk("t4_hold_data", o_m_data, d0);
        chk("t4_hold_rd", o_rd_ptr, 13'd5);
        drain("t4_drain");
        chk("t4_beats", n_beats - b0, 12);
        chk("t4_rd_ptr", o_rd_ptr, 13'd14);

        // 5: flush coinciding with an accepted beat
        i_wr_ptr = 13'd26;
        for (int i = 0; i < 100 && !o_m_valid; i++) step();
        chk("t5_reach", o_m_valid, 1'b1);
        b0 = n_beats;
        i_flush = 1'b1; i_m_ready = 1'b1;
        step();
        i_flush = 1'b0;
        chk("t5_valid", o_m_valid, 1'b0);
        chk("t5_rd_ptr", o_rd_ptr, 13'd26);
        chk("t5_empty", o_empty, 1'b1);
        repeat (10) step();
        chk("t5_nobeat", n_beats - b0, 0);

        // 6: asynchronous reset while waiting on BRAM data
        i_wr_ptr = 13'd40;
        for (int i = 0; i < 50 && !o_bram_rd_en; i++) step();
        chk("t6_fetch", o_bram_rd_en, 1'b1);
        step();
        chk("t6_busy", o_busy, 1'b1);
        i_reset_n = 1'b0;
        #1;
        chk("t6_valid", o_m_valid, 1'b0);
        chk("t6_rd_en", o_bram_rd_en, 1'b0);
        chk("t6_addr", o_bram_rd_addr, 9'd0);
        chk("t6_data", o_m_data, 16'd0);
        chk("t6_rd_ptr", o_rd_ptr, 13'd0);
        chk("t6_busy0", o_busy, 1'b0);
        chk("t6_empty", o_empty, 1'b1);
        do_reset();
        f0 = n_fetch;
        i_enable = 1'b1;
        repeat (10) step();
        chk("t6_no_read", n_fetch - f0, 0);
        chk("t6_empty_after", o_empty, 1'b1);

        // Random traffic: monotonic writer, random ready/enable, rare flushes
        for (int c = 0; c < 3000; c++) begin
            i_m_ready = ($urandom_range(0, 9) < 7);
            i_enable  = ($urandom_range(0, 9) != 0);
            i_flush   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) begin
                nw = i_wr_ptr + 13'($urandom_range(0, 40));
                if (13'(nw - m_rd) < 13'd1000) i_wr_ptr = nw;
            end
            step();
        end
        i_flush = 1'b0;
        drain("rnd_drain");
        chk("rnd_rd_ptr", o_rd_ptr, i_wr_ptr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/result_bram_reader.md
Name: result_bram_reader

Overview:
Drains the 8192-entry circular FP16 result buffer held in the 512 x 256-bit result BRAM, which is filled by the result-FIFO-to-BRAM writer. It reads whole lines, unpacks FP16 entries in order and streams them out on a 16-bit valid/ready interface. It owns the circular read pointer and returns it to the writer as that block's i_rd_ptr, which frees buffer space and releases its almost-full backpressure.

Parameters:
RD_LATENCY, 1, BRAM read latency in cycles from o_bram_rd_en to valid i_bram_rd_data; legal values 1..3.
WR_PTR_DLY, 1, register stages applied to i_wr_ptr before use; covers the writer updating its pointer one cycle before the BRAM write lands. Legal values 1..2.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_enable  in  1  permits new line fetches
i_flush  in  1  one-cycle pulse; discard all unread entries
i_wr_ptr  in  13  writer's FP16 write pointer (0-8191)
o_bram_rd_addr  out  9  BRAM line address
o_bram_rd_en  out  1  BRAM read strobe, one cycle per fetch
i_bram_rd_data  in  256  BRAM line; entry k is at bits [16k+15:16k]
o_m_data  out  16  FP16 result
o_m_valid  out  1  output beat valid
i_m_ready  in  1  downstream accept
o_rd_ptr  out  13  read pointer, drives writer i_rd_ptr
o_used_entries  out  14  (wr_ptr_d - rd_ptr) mod 8192
o_empty  out  1  wr_ptr_d == rd_ptr
o_busy  out  1  state != IDLE

Behaviour:
- Reset: i_reset_n is asynchronous, active-low; clock is i_clk.
- All outputs reset to 0: o_m_valid, o_bram_rd_en, o_bram_rd_addr, o_m_data, o_rd_ptr, o_busy. o_empty=1 and o_used_entries=0 follow from the reset pointers.
- Reset also clears the wr_ptr delay pipe, the line buffer and the state machine (to IDLE).
- wr_ptr_d: i_wr_ptr delayed WR_PTR_DLY registers. Only wr_ptr_d is used internally; i_wr_ptr is never used combinationally.
- used = wr_ptr_d - rd_ptr, computed in 14 bits, mod 8192. wr_ptr_d == rd_ptr means empty; the buffer is never treated as full.
- FSM states are IDLE, FETCH, WAIT, STREAM.
- IDLE: when i_enable=1 and used != 0, go to FETCH.
  - Capture lim = min(16, idx + used), where idx = rd_ptr[3:0]; lim is 5 bits.
- FETCH (1 cycle): drive o_bram_rd_en=1 and o_bram_rd_addr=rd_ptr[12:4], then go to WAIT.
- WAIT: count RD_LATENCY cycles, then latch i_bram_rd_data into the 256-bit line buffer and go to STREAM.
- STREAM:
  - o_m_valid=1 and o_m_data=buf[16*idx +: 16].
  - On o_m_valid & i_m_ready: rd_ptr increments, wrapping 8191 -> 0.
  - If idx+1 == lim, go to IDLE; otherwise stay in STREAM.
- Stale-data rule: entries at or above lim are never emitted from the current buffer. If more entries arrive for the same line, the line is re-fetched from IDLE.
- Output rule: while o_m_valid=1 and i_m_ready=0, o_m_data and o_m_valid hold stable.
- Throughput: up to one beat per cycle within a line. A bubble of RD_LATENCY+2 cycles is allowed per fetch.
- Wrap-around: line 511 is followed by line 0. A single fetch never spans lines.
- i_enable=0: blocks only the IDLE -> FETCH transition. Fetches in flight and the current line still complete.
- i_flush: has priority over everything. rd_ptr <= wr_ptr_d, state goes to IDLE, o_m_valid goes to 0 the next cycle.
  - A handshake in the same cycle is discarded and does not increment rd_ptr.
  - Read data that arrives later is ignored.
- i_wr_ptr moving backwards is not supported; the result is undefined.

Optional Feature:
RESULT_BRAM_READER_STATS_EN.
- Defined: adds outputs o_beat_count (32 bits; counts accepted beats, wraps) and o_stall_count (32 bits; counts cycles with o_m_valid=1 and i_m_ready=0). Both counters clear on reset and on i_flush.
- Undefined: neither port nor either counter exists; behaviour is otherwise identical.

Test Plan:
1. BRAM line 0 holds 0x1000+k for entry k; i_wr_ptr 0 -> 5; ready always 1 -> exactly 5 beats 0x1000..0x1004; one o_bram_rd_en at address 0; o_rd_ptr=5; o_empty=1.
2. i_wr_ptr=3 and drain, then i_wr_ptr=20 -> line 0 re-fetched giving entries 3..15, then line 1 giving entries 16..19; total 20 in-order beats; o_rd_ptr=20.
3. Flush with i_wr_ptr=8190 gives rd_ptr=8190; then i_wr_ptr=2 -> beats from line 511 idx 14,15 followed by line 0 idx 0,1; o_rd_ptr=2; o_used_entries peaks at 4.
4. i_m_ready=0 for 10 cycles in mid-line -> o_m_valid and o_m_data stable, o_rd_ptr unchanged; on release the stream resumes with no loss or duplication.
5. i_flush asserted in the same cycle as an accepted beat with used=12 -> no further beats; o_rd_ptr=wr_ptr_d; o_empty=1; next cycle o_m_valid=0.
6. Assert i_reset_n low during WAIT -> all outputs go to 0 immediately; after release, i_wr_ptr=0 gives o_empty=1 and no BRAM read.
